// File: rtl/fp_wrb_arbiter.sv
// ---------------------------------------------------------------------------
// fp_wrb_arbiter
//
// Collects floating-point writeback results from four producers and drives
// them onto the two write ports of the FP register file.
//
// Source index order: S0 = falu1, S1 = falu2, S2 = lsu, S3 = fdivsqrt.
//
// Each source owns a one-entry buffer. A handoff (request & ready) loads the
// buffer. Each cycle, up to two occupied buffers are granted. The search is
// round-robin and starts at pointer rr.
//
// Ports
//   clk, rst_n                  : clock and asynchronous active-low reset
//   <src>_valid_i               : source has a result this cycle
//   <src>_address_i / _data_i   : physical destination register and value
//   lsu_float_i                 : LSU result targets the FP regfile
//   <src>_ready_o               : source may hand off this cycle
//   wr_first_* / wr_second_*    : registered dual write port to the regfile
//   pending_cnt_o               : registered count of occupied buffers
// ---------------------------------------------------------------------------
module fp_wrb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  falu1_valid_i,
  input  logic [ADDR_WIDTH-1:0] falu1_address_i,
  input  logic [DATA_WIDTH-1:0] falu1_data_i,
  input  logic                  falu2_valid_i,
  input  logic [ADDR_WIDTH-1:0] falu2_address_i,
  input  logic [DATA_WIDTH-1:0] falu2_data_i,
  input  logic                  lsu_valid_i,
  input  logic                  lsu_float_i,
  input  logic [ADDR_WIDTH-1:0] lsu_address_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic                  fdivsqrt_valid_i,
  input  logic [ADDR_WIDTH-1:0] fdivsqrt_address_i,
  input  logic [DATA_WIDTH-1:0] fdivsqrt_data_i,
  output logic                  falu1_ready_o,
  output logic                  falu2_ready_o,
  output logic                  lsu_ready_o,
  output logic                  fdivsqrt_ready_o,
  output logic                  wr_first_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_first_address_o,
  output logic [DATA_WIDTH-1:0] wr_first_data_o,
  output logic                  wr_second_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_second_address_o,
  output logic [DATA_WIDTH-1:0] wr_second_data_o,
  output logic [2:0]            pending_cnt_o
);

  localparam int NSRC = 4;

  // Number of set bits in a 4-bit vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [3:0]            req_s;
  logic [3:0]            ready_s;
  logic [3:0]            grant_s;
  logic [3:0]            hand_s;
  logic [3:0]            load_s;
  logic [3:0]            pend_next_s;
  logic [3:0]            pend_r;
  logic [1:0]            rr_r;
  logic [1:0]            rr_next_s;
  logic [1:0]            scan_idx_s;
  logic                  first_found_s;
  logic                  second_found_s;
  logic [1:0]            first_idx_s;
  logic [1:0]            second_idx_s;
  logic [ADDR_WIDTH-1:0] in_addr_s [NSRC];
  logic [DATA_WIDTH-1:0] in_data_s [NSRC];
  logic [ADDR_WIDTH-1:0] addr_r    [NSRC];
  logic [DATA_WIDTH-1:0] data_r    [NSRC];
  logic                  wr_first_valid_r;
  logic [ADDR_WIDTH-1:0] wr_first_address_r;
  logic [DATA_WIDTH-1:0] wr_first_data_r;
  logic                  wr_second_valid_r;
  logic [ADDR_WIDTH-1:0] wr_second_address_r;
  logic [DATA_WIDTH-1:0] wr_second_data_r;
  logic [2:0]            pending_cnt_r;

  // The LSU also carries integer results; only FP results request here.
  assign req_s = {fdivsqrt_valid_i, lsu_valid_i & lsu_float_i,
                  falu2_valid_i, falu1_valid_i};

  assign in_addr_s[0] = falu1_address_i;
  assign in_addr_s[1] = falu2_address_i;
  assign in_addr_s[2] = lsu_address_i;
  assign in_addr_s[3] = fdivsqrt_address_i;
  assign in_data_s[0] = falu1_data_i;
  assign in_data_s[1] = falu2_data_i;
  assign in_data_s[2] = lsu_data_i;
  assign in_data_s[3] = fdivsqrt_data_i;

  // Round-robin scan from rr: the first two occupied buffers are granted.
  always_comb begin
    first_found_s  = 1'b0;
    second_found_s = 1'b0;
    first_idx_s    = 2'd0;
    second_idx_s   = 2'd0;
    scan_idx_s     = 2'd0;
    grant_s        = 4'b0000;
    for (int k = 0; k < NSRC; k++) begin
      scan_idx_s = rr_r + 2'(k);
      if (pend_r[scan_idx_s]) begin
        if (!first_found_s) begin
          first_found_s       = 1'b1;
          first_idx_s         = scan_idx_s;
          grant_s[scan_idx_s] = 1'b1;
        end else if (!second_found_s) begin
          second_found_s      = 1'b1;
          second_idx_s        = scan_idx_s;
          grant_s[scan_idx_s] = 1'b1;
        end else begin
          grant_s = grant_s;
        end
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // The pointer moves past the last granted source so it goes to the back of the order.
  always_comb begin
    rr_next_s = rr_r;
    if (second_found_s) begin
      rr_next_s = second_idx_s + 2'd1;
    end else if (first_found_s) begin
      rr_next_s = first_idx_s + 2'd1;
    end else begin
      rr_next_s = rr_r;
    end
  end

  // A buffer that drains this cycle can take a new entry at the same edge.
  assign ready_s = ~pend_r | grant_s;
  assign hand_s  = req_s & ready_s;

  // Writes to P0 are accepted but dropped, because P0 is never written.
  always_comb begin
    load_s      = 4'b0000;
    pend_next_s = pend_r;
    for (int s = 0; s < NSRC; s++) begin
      load_s[s] = hand_s[s] & (in_addr_s[s] != {ADDR_WIDTH{1'b0}});
      if (load_s[s]) begin
        pend_next_s[s] = 1'b1;
      end else if (grant_s[s]) begin
        pend_next_s[s] = 1'b0;
      end else begin
        pend_next_s[s] = pend_r[s];
      end
    end
  end

  // Buffer, pointer and write-port registers.
  // Write-port address and data hold their value when the port is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r              <= 4'b0000;
      rr_r                <= 2'd0;
      pending_cnt_r       <= 3'd0;
      wr_first_valid_r    <= 1'b0;
      wr_first_address_r  <= {ADDR_WIDTH{1'b0}};
      wr_first_data_r     <= {DATA_WIDTH{1'b0}};
      wr_second_valid_r   <= 1'b0;
      wr_second_address_r <= {ADDR_WIDTH{1'b0}};
      wr_second_data_r    <= {DATA_WIDTH{1'b0}};
      for (int s = 0; s < NSRC; s++) begin
        addr_r[s] <= {ADDR_WIDTH{1'b0}};
        data_r[s] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      pend_r        <= pend_next_s;
      rr_r          <= rr_next_s;
      pending_cnt_r <= popcount4(pend_next_s);
      for (int s = 0; s < NSRC; s++) begin
        if (load_s[s]) begin
          addr_r[s] <= in_addr_s[s];
          data_r[s] <= in_data_s[s];
        end
      end
      wr_first_valid_r <= first_found_s;
      if (first_found_s) begin
        wr_first_address_r <= addr_r[first_idx_s];
        wr_first_data_r    <= data_r[first_idx_s];
      end
      wr_second_valid_r <= second_found_s;
      if (second_found_s) begin
        wr_second_address_r <= addr_r[second_idx_s];
        wr_second_data_r    <= data_r[second_idx_s];
      end
    end
  end

  assign falu1_ready_o       = ready_s[0];
  assign falu2_ready_o       = ready_s[1];
  assign lsu_ready_o         = ready_s[2];
  assign fdivsqrt_ready_o    = ready_s[3];
  assign wr_first_valid_o    = wr_first_valid_r;
  assign wr_first_address_o  = wr_first_address_r;
  assign wr_first_data_o     = wr_first_data_r;
  assign wr_second_valid_o   = wr_second_valid_r;
  assign wr_second_address_o = wr_second_address_r;
  assign wr_second_data_o    = wr_second_data_r;
  assign pending_cnt_o       = pending_cnt_r;

endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_wrb_arbiter
//
// Directed scenarios run first, followed by randomized traffic. A
// transaction-level reference model keeps the expected state. For each source
// it holds an occupied flag, an address and data, plus a round-robin start
// index. The expected ready, write-port and pending-count values come from
// that model.
// ---------------------------------------------------------------------------
module tb_fp_wrb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        t_valid [4];
  logic [5:0]  t_addr  [4];
  logic [63:0] t_data  [4];
  logic        t_lsu_float = 1'b0;

  wire         r0, r1, r2, r3;
  wire         wr_first_valid_o, wr_second_valid_o;
  wire [5:0]   wr_first_address_o, wr_second_address_o;
  wire [63:0]  wr_first_data_o, wr_second_data_o;
  wire [2:0]   pending_cnt_o;
  wire [3:0]   ready_v = {r3, r2, r1, r0};

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_pend [4];
  logic [5:0]  m_addr [4];
  logic [63:0] m_data [4];
  int          m_rr;
  logic        e_fv, e_sv;
  logic [5:0]  e_fa, e_sa;
  logic [63:0] e_fd, e_sd;
  int          e_cnt;

  fp_wrb_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .falu1_valid_i      (t_valid[0]),
    .falu1_address_i    (t_addr[0]),
    .falu1_data_i       (t_data[0]),
    .falu2_valid_i      (t_valid[1]),
    .falu2_address_i    (t_addr[1]),
    .falu2_data_i       (t_data[1]),
    .lsu_valid_i        (t_valid[2]),
    .lsu_float_i        (t_lsu_float),
    .lsu_address_i      (t_addr[2]),
    .lsu_data_i         (t_data[2]),
    .fdivsqrt_valid_i   (t_valid[3]),
    .fdivsqrt_address_i (t_addr[3]),
    .fdivsqrt_data_i    (t_data[3]),
    .falu1_ready_o      (r0),
    .falu2_ready_o      (r1),
    .lsu_ready_o        (r2),
    .fdivsqrt_ready_o   (r3),
    .wr_first_valid_o   (wr_first_valid_o),
    .wr_first_address_o (wr_first_address_o),
    .wr_first_data_o    (wr_first_data_o),
    .wr_second_valid_o  (wr_second_valid_o),
    .wr_second_address_o(wr_second_address_o),
    .wr_second_data_o   (wr_second_data_o),
    .pending_cnt_o      (pending_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_pend[s] = 1'b0;
      m_addr[s] = 6'd0;
      m_data[s] = 64'd0;
    end
    m_rr = 0;
    e_fv = 1'b0; e_sv = 1'b0;
    e_fa = 6'd0; e_sa = 6'd0;
    e_fd = 64'd0; e_sd = 64'd0;
    e_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_fv"},  {63'd0, wr_first_valid_o},   {63'd0, e_fv});
    check({tag, "_fa"},  {58'd0, wr_first_address_o}, {58'd0, e_fa});
    check({tag, "_fd"},  wr_first_data_o,             e_fd);
    check({tag, "_sv"},  {63'd0, wr_second_valid_o},  {63'd0, e_sv});
    check({tag, "_sa"},  {58'd0, wr_second_address_o},{58'd0, e_sa});
    check({tag, "_sd"},  wr_second_data_o,            e_sd);
    check({tag, "_cnt"}, {61'd0, pending_cnt_o},      64'(e_cnt));
  endtask

  task automatic set_src(input int s, input logic v, input logic [5:0] a, input logic [63:0] d);
    t_valid[s] = v;
    t_addr[s]  = a;
    t_data[s]  = d;
  endtask

  task automatic clr_all();
    for (int s = 0; s < 4; s++) set_src(s, 1'b0, 6'd0, 64'd0);
    t_lsu_float = 1'b0;
  endtask

  // One clock: check ready against the model, let the edge happen, advance
  // the model by one transaction step and check the registered outputs.
  task automatic cycle(input string tag);
    int  order [$];
    int  granted [$];
    bit  gr  [4];
    bit  rdy [4];
    bit  req;
    int  cnt;
    for (int k = 0; k < 4; k++) order.push_back((m_rr + k) % 4);
    foreach (order[i]) if (m_pend[order[i]] && granted.size() < 2) granted.push_back(order[i]);
    for (int s = 0; s < 4; s++) gr[s] = 1'b0;
    foreach (granted[i]) gr[granted[i]] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rdy[s] = !m_pend[s] || gr[s];
      check($sformatf("%s_ready%0d", tag, s), {63'd0, ready_v[s]}, {63'd0, rdy[s]});
    end
    e_fv = 1'b0;
    e_sv = 1'b0;
    if (granted.size() >= 1) begin
      e_fv = 1'b1; e_fa = m_addr[granted[0]]; e_fd = m_data[granted[0]];
    end
    if (granted.size() >= 2) begin
      e_sv = 1'b1; e_sa = m_addr[granted[1]]; e_sd = m_data[granted[1]];
    end
    foreach (granted[i]) m_pend[granted[i]] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      req = t_valid[s] && (s != 2 || t_lsu_float);
      if (req && rdy[s] && t_addr[s] != 6'd0) begin
        m_pend[s] = 1'b1; m_addr[s] = t_addr[s]; m_data[s] = t_data[s];
      end
    end
    if (granted.size() > 0) m_rr = (granted[granted.size() - 1] + 1) % 4;
    cnt = 0;
    for (int s = 0; s < 4; s++) cnt += int'(m_pend[s]);
    e_cnt = cnt;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    clr_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // All four sources hand off together with rr=0.
    set_src(0, 1'b1, 6'd10, 64'h1010); set_src(1, 1'b1, 6'd11, 64'h1111);
    set_src(2, 1'b1, 6'd12, 64'h1212); set_src(3, 1'b1, 6'd13, 64'h1313);
    t_lsu_float = 1'b1;
    cycle("all4_e0");
    check("all4_cnt4", {61'd0, pending_cnt_o}, 64'd4);
    clr_all();
    cycle("all4_e1");
    check("all4_e1_first", {58'd0, wr_first_address_o}, 64'd10);
    check("all4_e1_second", {58'd0, wr_second_address_o}, 64'd11);
    cycle("all4_e2");
    check("all4_e2_first", {58'd0, wr_first_address_o}, 64'd12);
    check("all4_e2_second", {58'd0, wr_second_address_o}, 64'd13);

    // A single source (S1), with the latency of one edge into the buffer.
    set_src(1, 1'b1, 6'd5, 64'hAA);
    cycle("single_e0");
    check("single_e0_nowrite", {63'd0, wr_first_valid_o}, 64'd0);
    clr_all();
    cycle("single_e1");
    check("single_fv", {63'd0, wr_first_valid_o}, 64'd1);
    check("single_fa", {58'd0, wr_first_address_o}, 64'd5);
    check("single_fd", wr_first_data_o, 64'hAA);
    check("single_sv", {63'd0, wr_second_valid_o}, 64'd0);
    check("single_cnt", {61'd0, pending_cnt_o}, 64'd0);

    // An LSU integer result is not a request.
    set_src(2, 1'b1, 6'd7, 64'h77); t_lsu_float = 1'b0;
    cycle("lsuint_e0");
    clr_all();
    cycle("lsuint_e1");
    check("lsuint_nowrite", {63'd0, wr_first_valid_o}, 64'd0);

    // A handoff to address 0 is accepted and dropped.
    set_src(3, 1'b1, 6'd0, 64'h33);
    cycle("p0_e0");
    check("p0_cnt", {61'd0, pending_cnt_o}, 64'd0);
    clr_all();
    cycle("p0_e1");
    check("p0_nowrite", {63'd0, wr_first_valid_o}, 64'd0);

    // S0 keeps requesting while S1..S3 are buffered.
    set_src(1, 1'b1, 6'd21, 64'h21); set_src(2, 1'b1, 6'd22, 64'h22);
    set_src(3, 1'b1, 6'd23, 64'h23); t_lsu_float = 1'b1;
    cycle("starve_load");
    clr_all();
    for (int i = 0; i < 5; i++) begin
      set_src(0, 1'b1, 6'(30 + i), 64'(i));
      cycle($sformatf("starve%0d", i));
    end
    clr_all();
    repeat (3) cycle("starve_drain");

    // An asynchronous reset is applied while three entries are pending.
    set_src(0, 1'b1, 6'd40, 64'h40); set_src(1, 1'b1, 6'd41, 64'h41);
    set_src(2, 1'b1, 6'd42, 64'h42); t_lsu_float = 1'b1;
    cycle("arst_load");
    clr_all();
    cycle("arst_one");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_src(2, 1'b1, 6'd50, 64'h5050); t_lsu_float = 1'b1;
    cycle("arst_after_e0");
    clr_all();
    cycle("arst_after_e1");
    check("arst_after_fa", {58'd0, wr_first_address_o}, 64'd50);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 4; s++) begin
        set_src(s, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                {$urandom, $urandom});
      end
      t_lsu_float = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_wrb_arbiter.md
FP_WRB_ARBITER -- requirements
Module: fp_wrb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, physical register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, writeback data width.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports falu1_/falu2_/lsu_/fdivsqrt_ valid_i (input, 1), address_i (input, ADDR_WIDTH) and data_i (input, DATA_WIDTH): four writeback sources, indexed S0..S3 in that order.
REQ-006 SHALL have port lsu_float_i, input, 1 bit: LSU result is floating-point; S2 request = lsu_valid_i & lsu_float_i.
REQ-007 SHALL have ports falu1_/falu2_/lsu_/fdivsqrt_ ready_o, output, 1 bit each: source may hand off this cycle.
REQ-008 SHALL have ports wr_first_valid_o and wr_second_valid_o (output, 1), wr_first_address_o and wr_second_address_o (output, ADDR_WIDTH), and wr_first_data_o and wr_second_data_o (output, DATA_WIDTH): registered dual write port to the FP regfile.
REQ-009 SHALL have port pending_cnt_o, output, 3 bits: number of occupied source buffers.

Function
REQ-010 SHALL hold one entry buffer per source: pend[s], addr, data.
REQ-011 Handoff SHALL occur when request & ready_o are high at a rising edge; the entry is loaded into pend[s].
REQ-012 ready_o[s] SHALL = !pend[s] | grant[s] (combinational), allowing back-to-back handoff per source.
REQ-013 Handoff with address 0 SHALL be accepted and discarded; pend[s] is not set; no write is ever issued to P0.
REQ-014 Each cycle, the arbiter SHALL grant up to two pending buffers, scanning round-robin from pointer rr (2 bits).
REQ-015 The first granted source SHALL drive wr_first_*, the second wr_second_*, registered at the next edge.
REQ-016 A write port with no grant SHALL have valid_o=0 after the edge; its address and data SHALL hold their previous values.
REQ-017 Granted buffers SHALL clear at the same edge unless a new handoff reloads them.
REQ-018 rr SHALL advance to (last granted index + 1) mod 4 when any grant occurs; otherwise it is unchanged.
REQ-019 Latency: handoff at edge E SHALL appear on wr_* no earlier than after edge E+1 (minimum 2 edges from request to visible write).
REQ-020 Starvation bound: a pending entry SHALL be granted within 2 cycles of becoming pending.
REQ-021 pending_cnt_o SHALL be the registered popcount of pend[3:0], range 0..4.
REQ-022 Requests presented while ready_o=0 SHALL be ignored; sources hold them stable (not checked).
REQ-023 Same-address entries from different sources SHALL be undefined; rename guarantees uniqueness; no comparison is required.

Reset
REQ-024 While rst_n=0, all pend SHALL = 0, rr = 0, wr_*_valid_o = 0, wr_*_address_o = 0, wr_*_data_o = 0, and pending_cnt_o = 0.
REQ-025 Reset assertion mid-operation SHALL immediately drop buffered entries and output valids, with no partial write.
REQ-026 After deassertion, all ready_o SHALL be 1 in the first cycle.

Verification
REQ-027 Single source: S1 hands off addr 5, data 0xAA at E0 -> wr_first valid, addr 5, data 0xAA after E1; wr_second_valid=0; pending_cnt back to 0.
REQ-028 All four hand off at E0 with rr=0 -> after E1 write S0 (first) and S1 (second), rr=2; after E2 write S2 and S3, rr=0.
REQ-029 LSU with lsu_float_i=0, valid=1 -> no handoff, no write, pending_cnt unchanged.
REQ-030 Address 0 from S3 -> ready_o=1, no write issued, pend[3] stays 0.
REQ-031 S0 continuously requesting with S1..S3 buffered -> each of S1..S3 is granted within 2 cycles; S0 ready_o toggles per REQ-012.
REQ-032 rst_n pulled low asynchronously with 3 pending entries -> outputs zero before the next edge; after release, a new handoff is written normally.
